game_sequencer: RTL

//  Game-flow controller between keyboard/buttons, collision detect and sprite drivers.
//  FSM sequences IDLE/PLAY/HIT/OVER, gates char_driver and enemy enables, and

---
 rtl/game_sequencer_if.sv | 30 +++
 rtl/game_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: bundles the game-flow inputs (vs/start/hit) and the sequencer outputs.
// Latency: none, wires only.
// Backpressure: none; every signal is a level sampled each pixel_clk.
interface game_sequencer_if #(
  parameter int N_ENEMY = 16,
  parameter int SCORE_W = 16
);
  logic               vs;
  logic               start;
  logic               hit;
  logic               char_en;
  logic               enemy_en;
  logic [N_ENEMY-1:0] spawn_mask;
  logic               hit_flash;
  logic [2:0]         lives;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;

  // Environment side: VGA timing, buttons and collision detect drive the inputs.
  modport master (
    output vs, start, hit,
    input  char_en, enemy_en, spawn_mask, hit_flash, lives, score, state
  );

  // Sequencer side.
  modport slave (
    input  vs, start, hit,
    output char_en, enemy_en, spawn_mask, hit_flash, lives, score, state
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: IDLE/PLAY/HIT/OVER game flow, lives, score, staggered enemy spawn (opt GAME_SEQ_EXTRA_LIFE_EN).
// Latency: every output registered, changes one pixel_clk after the vs/start/hit event cycle.
// Backpressure: none; vs/start are edge-detected, hit is a level checked every PLAY cycle.
module game_sequencer #(
  parameter int N_ENEMY      = 16,
  parameter int LIVES_INIT   = 3,
  parameter int SPAWN_FRAMES = 30,
  parameter int HIT_FRAMES   = 60,
  parameter int SCORE_W      = 16,
  parameter int LIVES_MAX    = 7
) (
  input  logic             pixel_clk,
  input  logic             CPU_RESETN,
  game_sequencer_if.slave  bus
);
  localparam int SPW = $clog2(SPAWN_FRAMES + 1);
  localparam int HTW = $clog2(HIT_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t             st;
  logic               vs_q;
  logic               start_q;
  logic               char_en_r;
  logic               enemy_en_r;
  logic               flash_r;
  logic [N_ENEMY-1:0] mask_r;
  logic [2:0]         lives_r;
  logic [SCORE_W-1:0] score_r;
  logic [SPW-1:0]     spawn_cnt;
  logic [HTW-1:0]     hit_cnt;

  logic               frame_tick;
  logic               start_rise;
  logic [SCORE_W-1:0] score_inc;
  logic               spawn_wrap;
  logic               hit_done;
  logic [2:0]         lives_up;
  logic               award;

  // Edge detectors: the delayed copies reset high so a level held through reset is not an edge.
  assign frame_tick = bus.vs & ~vs_q;
  assign start_rise = bus.start & ~start_q;

  // Score saturates at all-ones rather than wrapping back to zero.
  assign score_inc  = (&score_r) ? score_r : score_r + {{(SCORE_W-1){1'b0}}, 1'b1};
  assign spawn_wrap = (spawn_cnt == SPW'(SPAWN_FRAMES - 1));
  assign hit_done   = (hit_cnt == HTW'(HIT_FRAMES - 1));
  assign lives_up   = (lives_r < 3'(LIVES_MAX)) ? lives_r + 3'd1 : lives_r;

`ifdef GAME_SEQ_EXTRA_LIFE_EN
  // Bonus life each time the incremented score crosses a multiple of 1024.
  assign award = (score_inc[9:0] == 10'd0) && (score_inc != '0);
`else
  assign award = 1'b0;
`endif

  // Game-flow FSM with all outputs and counters registered alongside the state.
  always_ff @(posedge pixel_clk or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      st         <= S_IDLE;
      vs_q       <= 1'b1;
      start_q    <= 1'b1;
      char_en_r  <= 1'b1;
      enemy_en_r <= 1'b0;
      flash_r    <= 1'b0;
      mask_r     <= '0;
      lives_r    <= 3'(LIVES_INIT);
      score_r    <= '0;
      spawn_cnt  <= '0;
      hit_cnt    <= '0;
    end else begin
      vs_q    <= bus.vs;
      start_q <= bus.start;
      case (st)
        S_IDLE: begin
          if (start_rise) begin
            st         <= S_PLAY;
            lives_r    <= 3'(LIVES_INIT);
            score_r    <= '0;
            spawn_cnt  <= '0;
            mask_r     <= '0;
            char_en_r  <= 1'b1;
            enemy_en_r <= 1'b1;
            flash_r    <= 1'b0;
          end
        end
        S_PLAY: begin
          // A hit outranks a same-cycle frame tick: no score, spawn or bonus that cycle.
          if (bus.hit) begin
            char_en_r  <= 1'b0;
            enemy_en_r <= 1'b0;
            flash_r    <= 1'b1;
            hit_cnt    <= '0;
            if (lives_r <= 3'd1) begin
              lives_r <= 3'd0;
              st      <= S_OVER;
            end else begin
              lives_r <= lives_r - 3'd1;
              st      <= S_HIT;
            end
          end else if (frame_tick) begin
            score_r <= score_inc;
            if (award) begin
              lives_r <= lives_up;
            end
            if (spawn_wrap) begin
              spawn_cnt <= '0;
              mask_r    <= {mask_r[N_ENEMY-2:0], 1'b1};
            end else begin
              spawn_cnt <= spawn_cnt + SPW'(1);
            end
          end
        end
        S_HIT: begin
          // Frozen; enemies respawn from slot 0 when play resumes.
          if (frame_tick) begin
            if (hit_done) begin
              st         <= S_PLAY;
              hit_cnt    <= '0;
              spawn_cnt  <= '0;
              mask_r     <= '0;
              char_en_r  <= 1'b1;
              enemy_en_r <= 1'b1;
              flash_r    <= 1'b0;
            end else begin
              hit_cnt <= hit_cnt + HTW'(1);
            end
          end
        end
        S_OVER: begin
          if (start_rise) begin
            st         <= S_IDLE;
            mask_r     <= '0;
            char_en_r  <= 1'b1;
            enemy_en_r <= 1'b0;
            flash_r    <= 1'b0;
          end
        end
      endcase
    end
  end

  // Drive the registered state onto the bus.
  always_comb begin
    bus.char_en    = char_en_r;
    bus.enemy_en   = enemy_en_r;
    bus.spawn_mask = mask_r;
    bus.hit_flash  = flash_r;
    bus.lives      = lives_r;
    bus.score      = score_r;
    bus.state      = st;
  end
endmodule
